// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_timing_gen : parametrised VGA raster counters, syncs and frame ticks   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int CLK_DIV   = 1,
   parameter int HSYNC_POL = 0,
   parameter int VSYNC_POL = 0,
   parameter int COORD_W   = 11,
   parameter int FRAME_W   = 16
) (
   input  logic               Clock,
   input  logic               Reset,
   output logic               oPixelEn,
   output logic               oVideoOn,
   output logic [COORD_W-1:0] oColCurrent,
   output logic [COORD_W-1:0] oRowCurrent,
   output logic               oVgaHsync,
   output logic               oVgaVsync,
   output logic               oLineStart,
   output logic               oFrameStart,
   output logic [FRAME_W-1:0] oFrameCount
);

   localparam int c_H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int c_V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
   localparam logic [COORD_W-1:0] c_H_LAST    = COORD_W'(c_H_TOTAL - 1);
   localparam logic [COORD_W-1:0] c_V_LAST    = COORD_W'(c_V_TOTAL - 1);
   localparam logic [COORD_W-1:0] c_H_VIS     = COORD_W'(H_VISIBLE);
   localparam logic [COORD_W-1:0] c_V_VIS     = COORD_W'(V_VISIBLE);
   localparam logic [COORD_W-1:0] c_HS_FIRST  = COORD_W'(H_VISIBLE + H_FRONT);
   localparam logic [COORD_W-1:0] c_HS_LAST   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [COORD_W-1:0] c_VS_FIRST  = COORD_W'(V_VISIBLE + V_FRONT);
   localparam logic [COORD_W-1:0] c_VS_LAST   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic               c_HS_ACT    = (HSYNC_POL != 0);
   localparam logic               c_VS_ACT    = (VSYNC_POL != 0);

   if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
   end
   if (((c_H_TOTAL - 1) >> COORD_W) != 0 || ((c_V_TOTAL - 1) >> COORD_W) != 0) begin : g_bad_coord_w
      $error("vga_timing_gen: COORD_W too narrow for the raster totals");
   end

   logic               run_q;
   logic [c_DIV_W-1:0] div_q,   div_d;
   logic [COORD_W-1:0] col_q,   col_d;
   logic [COORD_W-1:0] row_q,   row_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               pix_q,   pix_d;
   logic               von_q,   von_d;
   logic               hs_q,    hs_d;
   logic               vs_q,    vs_d;
   logic               ls_q,    ls_d;
   logic               fs_q,    fs_d;

   // The first clock out of reset presents (0,0) without advancing, so that
   // the frame counter only counts frames completed by wrapping.
   always_comb begin
      div_d   = '0;
      col_d   = '0;
      row_d   = '0;
      frame_d = frame_q;
      pix_d   = 1'b1;
      if (run_q) begin
         pix_d = (div_q == c_DIV_LAST);
         div_d = pix_d ? '0 : div_q + c_DIV_W'(1);
         col_d = col_q;
         row_d = row_q;
         if (pix_d) begin
            if (col_q == c_H_LAST) begin
               col_d = '0;
               if (row_q == c_V_LAST) begin
                  row_d   = '0;
                  frame_d = frame_q + FRAME_W'(1);
               end else begin
                  row_d = row_q + COORD_W'(1);
               end
            end else begin
               col_d = col_q + COORD_W'(1);
            end
         end
      end
      // Decode from the next-state position so flags line up with coordinates.
      von_d = (col_d < c_H_VIS) && (row_d < c_V_VIS);
      hs_d  = ((col_d >= c_HS_FIRST) && (col_d <= c_HS_LAST)) ? c_HS_ACT : ~c_HS_ACT;
      vs_d  = ((row_d >= c_VS_FIRST) && (row_d <= c_VS_LAST)) ? c_VS_ACT : ~c_VS_ACT;
      ls_d  = pix_d && (col_d == '0);
      fs_d  = ls_d && (row_d == '0);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         run_q   <= 1'b0;
         div_q   <= '0;
         col_q   <= '0;
         row_q   <= '0;
         frame_q <= '0;
         pix_q   <= 1'b0;
         von_q   <= 1'b0;
         hs_q    <= ~c_HS_ACT;
         vs_q    <= ~c_VS_ACT;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         run_q   <= 1'b1;
         div_q   <= div_d;
         col_q   <= col_d;
         row_q   <= row_d;
         frame_q <= frame_d;
         pix_q   <= pix_d;
         von_q   <= von_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         ls_q    <= ls_d;
         fs_q    <= fs_d;
      end
   end

   assign oPixelEn    = pix_q;
   assign oVideoOn    = von_q;
   assign oColCurrent = col_q;
   assign oRowCurrent = row_q;
   assign oVgaHsync   = hs_q;
   assign oVgaVsync   = vs_q;
   assign oLineStart  = ls_q;
   assign oFrameStart = fs_q;
   assign oFrameCount = frame_q;

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the snake game display path. Owns the horizontal/vertical counters, drives the monitor sync pins and gives pixel renderers the current coordinate, a visible-area flag and a pixel-rate strobe. Adds configurable resolution, porch widths, sync polarity and a clock divider to the fixed 640x480 controller. Adds line/frame start pulses and a frame counter that game logic uses as a movement tick.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, pixels
- H_SYNC, 96, hsync width, pixels
- H_BACK, 48, horizontal back porch, pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, vsync width, lines
- V_BACK, 33, vertical back porch, lines
- CLK_DIV, 1, clocks per pixel (>=1)
- HSYNC_POL, 0, hsync active level (0 = active low)
- VSYNC_POL, 0, vsync active level
- COORD_W, 11, coordinate width
- FRAME_W, 16, frame counter width

Ports:
- Clock  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- oPixelEn  out  1  one-clock strobe on first clock of each pixel position
- oVideoOn  out  1  current position is in the visible area
- oColCurrent  out  COORD_W  current column, 0..H_TOTAL-1
- oRowCurrent  out  COORD_W  current row, 0..V_TOTAL-1
- oVgaHsync  out  1  horizontal sync
- oVgaVsync  out  1  vertical sync
- oLineStart  out  1  one-clock pulse when column becomes 0
- oFrameStart  out  1  one-clock pulse when position becomes (0,0)
- oFrameCount  out  FRAME_W  completed frames, wraps mod 2^FRAME_W

## Operation
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Elaboration error if CLK_DIV < 1. Elaboration error if H_TOTAL-1 or V_TOTAL-1 does not fit in COORD_W.
- Divider counts 0..CLK_DIV-1. The position advances when the divider wraps.
- Column advance: col+1; at H_TOTAL-1 col wraps to 0 and row increments. Row at V_TOTAL-1 wraps to 0 with column wrap.
- Each return to (0,0) via wrap increments oFrameCount.
- oVideoOn = col < H_VISIBLE and row < V_VISIBLE.
- Hsync active for H_VISIBLE+H_FRONT <= col <= H_VISIBLE+H_FRONT+H_SYNC-1. Output level is HSYNC_POL when active, the inverse otherwise.
- Vsync active for whole rows V_VISIBLE+V_FRONT .. V_VISIBLE+V_FRONT+V_SYNC-1, including their porch columns. Output polarity per VSYNC_POL.
- oLineStart and oFrameStart are qualified by oPixelEn, so each is high for exactly one clock per line or frame.

## Timing
- All outputs are registered. Within any one clock, coordinate, oVideoOn, syncs and pulses all describe the same position: sync/flag decode is done from next-state counters, not delayed by one clock.
- While Reset is high:
  - col = 0, row = 0, divider = 0, oFrameCount = 0
  - oPixelEn = 0, oVideoOn = 0, oLineStart = 0, oFrameStart = 0
  - oVgaHsync = ~HSYNC_POL, oVgaVsync = ~VSYNC_POL
- First clock after Reset falls: position (0,0), oPixelEn = 1, oVideoOn = 1, oLineStart = 1, oFrameStart = 1, oFrameCount = 0.
- Each position is held for CLK_DIV clocks. oPixelEn is high only on the first of those clocks; with CLK_DIV = 1 it is constantly high after reset.
- Line period = H_TOTAL*CLK_DIV clocks. Frame period = H_TOTAL*V_TOTAL*CLK_DIV clocks.
- oFrameCount increments in the same clock that oFrameStart pulses, except the first frame after reset. Wrap from 2^FRAME_W-1 to 0 is silent.
- Reset mid-frame: the next clock shows the reset state and all pulses are suppressed. Restart from (0,0) follows as above, with no partial sync pulse extension.

## Test plan
- Reset for 20 clocks, then release. During reset: col/row 0, syncs 1 (POL=0), videoOn 0, frameCount 0. First clock after release: (0,0), videoOn 1, frameStart 1.
- Small params H=8/2/2/2, V=4/1/1/1, CLK_DIV=1:
  - videoOn high for cols 0..7; hsync low for cols 10..11.
  - lineStart every 14 clocks; vsync low for all of row 5.
  - frameStart every 98 clocks; frameCount = 1 at clock 98 after release.
- Same params with CLK_DIV=2: oPixelEn alternates 1/0, each column is held 2 clocks, frame period is 196 clocks.
- HSYNC_POL=1, VSYNC_POL=1: hsync high only on cols 10..11, vsync high only on row 5, both low during reset.
- Assert Reset at (5,3) for 1 clock: next clock shows the reset state. The clock after that shows (0,0) with frameStart 1 and frameCount 0.
- Defaults: frame is 800x525 = 420000 clocks. hsync low for 96 clocks from col 656. vsync low for rows 490..491. Force frameCount from 0xFFFF and check it wraps to 0.
